flunky_cluster_csr: RTL and testbench
=====================================

Name: flunky_cluster_csr

Overview:
- APB3 control/status slave for a multi-core flunky cluster. It generalises the single-core control register and GPIO wrapper to NUM_CORES cores and GPIO_WIDTH pins.
- Per-core reset sequencing with a guaranteed minimum reset-hold time.
- GPIO input synchronisation, rising-edge capture with W1C clear, and a maskable interrupt.
- Sits between the APB fabric and the core array; pin tristating stays in the top level.

Parameters:
- NUM_CORES, 4, number of cores with individually controlled resets (1..32).
- GPIO_WIDTH, 8, number of GPIO pins (1..32).
- RST_HOLD, 16, minimum cycles core_resetn stays low after any assertion (>=2).
- ADDR_WIDTH, 12, APB address width; byte addressed, word aligned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- paddr  in  ADDR_WIDTH  APB address
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- core_resetn  out  NUM_CORES  per-core active-low reset, registered
- gpi  in  GPIO_WIDTH  raw, asynchronous pin inputs
- gpo  out  GPIO_WIDTH  pin output values
- gpen  out  GPIO_WIDTH  pin output enables
- irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock is used, with synchronous active-high reset named `reset`. All state updates on the rising edge of clk.
- APB handshake:
  - pready is tied to 1, so there are no wait states.
  - A write commits on the edge where psel&penable&pwrite=1.
  - prdata is combinational from paddr while psel=1, and 0 otherwise. Reads have no side effects.
  - pslverr=1 during the access phase for an unmapped offset. In that case the read returns 0 and the write is ignored.
- Register map (offset, access):
  - 0x00 CORE_RUN (RW): run request per core in bits [NUM_CORES-1:0]. Reset value 0.
  - 0x04 CORE_STAT (RO): current core_resetn in bits [NUM_CORES-1:0], and hold-done flags in bits [NUM_CORES+15:16].
  - 0x08 GPIO_OUT (RW): drives gpo. Reset value 0.
  - 0x0C GPIO_OE (RW): drives gpen. Reset value 0.
  - 0x10 GPIO_IN (RO): synchronised pin values.
  - 0x14 GPIO_EDGE (W1C): captured rising edges. Reset value 0.
  - 0x18 GPIO_IE (RW): interrupt enables. Reset value 0.
  - 0x1C ID (RO): {8'hF5, NUM_CORES[7:0], GPIO_WIDTH[7:0], 8'h02}.
  - Bits above the parameter width in any register read as 0 and ignore writes.
- Per-core sequencer: one FSM and one counter per core, wide enough for RST_HOLD-1.
  - HOLD: core_resetn=0. The counter increments each cycle. When count==RST_HOLD-1, go to WAIT.
  - WAIT: core_resetn=0. If CORE_RUN[i]=1, go to RUN.
  - RUN: core_resetn=1. If CORE_RUN[i]=0, go to HOLD with count=0.
  - core_resetn is a registered decode of the next state. Setting CORE_RUN in WAIT gives core_resetn=1 on the edge after the write edge. Clearing CORE_RUN in RUN gives core_resetn=0 on the edge after the write.
  - CORE_RUN changes during HOLD are latched into the register but take no effect until HOLD completes. A set run bit then releases the core 1 cycle after entering WAIT.
  - Minimum low time is RST_HOLD+1 cycles from entry to HOLD.
- Reset:
  - All FSMs go to HOLD with count 0, and core_resetn=0.
  - gpo=0, gpen=0, irq=0, and all registers take their reset values.
  - Synchroniser flops are cleared to 0.
  - Asserting reset mid-run forces all cores low on that edge and restarts the full hold.
- GPIO input path:
  - 2-flop synchroniser produces GPIO_IN, followed by one history flop.
  - rise = GPIO_IN & ~history.
  - gpi changing before edge k appears in GPIO_IN after edge k+1 and in GPIO_EDGE after edge k+2.
- GPIO_EDGE update: EDGE <= (EDGE & ~w1c_mask) | rise. On the same cycle, a set caused by a rising edge wins over a W1C clear.
- irq = |(GPIO_EDGE & GPIO_IE), combinational from registers. It stays asserted until all enabled set bits are cleared.
- GPIO_IE changes affect irq in the cycle after the write edge.

Test Plan:
- Reset, then read all offsets → core_resetn=4'b0000, CORE_STAT=0, GPIO_OUT/OE/EDGE/IE=0, ID=32'hF5040802; a read of 0x20 gives pslverr=1 and prdata=0.
- Wait 20 cycles and write CORE_RUN=4'b0101 → core_resetn=4'b0101 one cycle after the write; CORE_STAT[19:16]=4'hF; cores 1 and 3 stay low.
- With core 0 in RUN, write CORE_RUN=0 and then 1 on the next access → core_resetn[0] drops and stays low for exactly RST_HOLD+1=17 cycles before rising again.
- Write GPIO_OE=8'hF0 and GPIO_OUT=8'hA5 → gpen=8'hF0 and gpo=8'hA5 on the edge after each write; readback matches.
- Write GPIO_IE=8'h01, then drive gpi[0] 0→1 before edge k → GPIO_IN[0]=1 after k+1, GPIO_EDGE=8'h01 and irq=1 after k+2; W1C 8'h01 clears both; a falling edge sets nothing.
- W1C GPIO_EDGE bit 2 on the same cycle that gpi[2] produces a rise → bit 2 remains 1.

Source files
------------

// File: rtl/flunky_cluster_csr.sv
// APB3 control/status slave for a multi-core flunky cluster: per-core reset
// sequencing with a guaranteed hold time, plus GPIO output, input sync and edge interrupt.
module flunky_cluster_csr #(
    parameter int NUM_CORES  = 4,
    parameter int GPIO_WIDTH = 8,
    parameter int RST_HOLD   = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [NUM_CORES-1:0]  core_resetn,
    input  logic [GPIO_WIDTH-1:0] gpi,
    output logic [GPIO_WIDTH-1:0] gpo,
    output logic [GPIO_WIDTH-1:0] gpen,
    output logic                  irq
);

    localparam int CW   = $clog2(RST_HOLD);
    localparam int HD_W = (NUM_CORES > 16) ? 16 : NUM_CORES;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

    localparam logic [ADDR_WIDTH-1:0] OFF_CORE_RUN  = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] OFF_CORE_STAT = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] OFF_GPIO_OUT  = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] OFF_GPIO_OE   = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] OFF_GPIO_IN   = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] OFF_GPIO_EDGE = ADDR_WIDTH'(8'h14);
    localparam logic [ADDR_WIDTH-1:0] OFF_GPIO_IE   = ADDR_WIDTH'(8'h18);
    localparam logic [ADDR_WIDTH-1:0] OFF_ID        = ADDR_WIDTH'(8'h1C);

    localparam logic [7:0]  ID_CORES = 8'(NUM_CORES);
    localparam logic [7:0]  ID_GPIO  = 8'(GPIO_WIDTH);
    localparam logic [31:0] ID_VALUE = {8'hF5, ID_CORES, ID_GPIO, 8'h02};

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } core_state_t;

    logic [NUM_CORES-1:0]  core_run_r;
    logic [NUM_CORES-1:0]  core_resetn_s;
    logic [NUM_CORES-1:0]  hold_done_s;
    logic [GPIO_WIDTH-1:0] gpio_out_r;
    logic [GPIO_WIDTH-1:0] gpio_oe_r;
    logic [GPIO_WIDTH-1:0] gpio_ie_r;
    logic [GPIO_WIDTH-1:0] gpio_edge_r;
    logic [GPIO_WIDTH-1:0] sync1_r;
    logic [GPIO_WIDTH-1:0] gpio_in_r;
    logic [GPIO_WIDTH-1:0] hist_r;
    logic [GPIO_WIDTH-1:0] rise_s;
    logic [GPIO_WIDTH-1:0] w1c_s;
    logic [31:0]           rdata_s;
    logic                  mapped_s;
    logic                  wr_s;

    assign wr_s   = psel & penable & pwrite;
    assign rise_s = gpio_in_r & ~hist_r;
    assign pready = 1'b1;

    // Read decode: unmapped offsets read as zero and flag an error.
    always_comb begin
        rdata_s  = 32'h0000_0000;
        mapped_s = 1'b1;
        case (paddr)
            OFF_CORE_RUN:  rdata_s[NUM_CORES-1:0] = core_run_r;
            OFF_CORE_STAT: begin
                rdata_s[NUM_CORES-1:0] = core_resetn_s;
                rdata_s[16 +: HD_W]    = hold_done_s[HD_W-1:0];
            end
            OFF_GPIO_OUT:  rdata_s[GPIO_WIDTH-1:0] = gpio_out_r;
            OFF_GPIO_OE:   rdata_s[GPIO_WIDTH-1:0] = gpio_oe_r;
            OFF_GPIO_IN:   rdata_s[GPIO_WIDTH-1:0] = gpio_in_r;
            OFF_GPIO_EDGE: rdata_s[GPIO_WIDTH-1:0] = gpio_edge_r;
            OFF_GPIO_IE:   rdata_s[GPIO_WIDTH-1:0] = gpio_ie_r;
            OFF_ID:        rdata_s = ID_VALUE;
            default:       mapped_s = 1'b0;
        endcase
    end

    // Bus outputs and the W1C mask for the edge register.
    always_comb begin
        if (psel) begin
            prdata = rdata_s;
        end else begin
            prdata = 32'h0000_0000;
        end
        pslverr = psel & penable & ~mapped_s;
        if (wr_s && (paddr == OFF_GPIO_EDGE)) begin
            w1c_s = pwdata[GPIO_WIDTH-1:0];
        end else begin
            w1c_s = '0;
        end
    end

    // Writable registers and the GPIO input synchroniser/edge capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_run_r  <= '0;
            gpio_out_r  <= '0;
            gpio_oe_r   <= '0;
            gpio_ie_r   <= '0;
            gpio_edge_r <= '0;
            sync1_r     <= '0;
            gpio_in_r   <= '0;
            hist_r      <= '0;
        end else begin
            if (wr_s && (paddr == OFF_CORE_RUN)) core_run_r <= pwdata[NUM_CORES-1:0];
            if (wr_s && (paddr == OFF_GPIO_OUT)) gpio_out_r <= pwdata[GPIO_WIDTH-1:0];
            if (wr_s && (paddr == OFF_GPIO_OE))  gpio_oe_r  <= pwdata[GPIO_WIDTH-1:0];
            if (wr_s && (paddr == OFF_GPIO_IE))  gpio_ie_r  <= pwdata[GPIO_WIDTH-1:0];
            // A rise in the same cycle as a clear must survive, so OR it in last.
            gpio_edge_r <= (gpio_edge_r & ~w1c_s) | rise_s;
            sync1_r     <= gpi;
            gpio_in_r   <= sync1_r;
            hist_r      <= gpio_in_r;
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_state_t   state_r;
        logic [CW-1:0] cnt_r;
        logic          resetn_r;

        // Reset sequencer; resetn_r is the registered decode of the next state.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r  <= ST_HOLD;
                cnt_r    <= '0;
                resetn_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_HOLD: begin
                        resetn_r <= 1'b0;
                        if (cnt_r == HOLD_LAST) begin
                            state_r <= ST_WAIT;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (core_run_r[i]) begin
                            state_r  <= ST_RUN;
                            resetn_r <= 1'b1;
                        end else begin
                            resetn_r <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!core_run_r[i]) begin
                            state_r  <= ST_HOLD;
                            cnt_r    <= '0;
                            resetn_r <= 1'b0;
                        end else begin
                            resetn_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= ST_HOLD;
                        cnt_r    <= '0;
                        resetn_r <= 1'b0;
                    end
                endcase
            end
        end

        assign core_resetn_s[i] = resetn_r;
        assign hold_done_s[i]   = (state_r != ST_HOLD);
    end

    assign core_resetn = core_resetn_s;
    assign gpo         = gpio_out_r;
    assign gpen        = gpio_oe_r;
    assign irq         = |(gpio_edge_r & gpio_ie_r);

endmodule

// File: tb/tb_flunky_cluster_csr.sv
// Directed self-checking bench for flunky_cluster_csr; expected values are
// queued when a transaction is driven and compared when the DUT answers.
module tb_flunky_cluster_csr;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [3:0]  core_resetn;
    logic [7:0]  gpi, gpo, gpen;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    flunky_cluster_csr dut (
        .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .core_resetn(core_resetn), .gpi(gpi), .gpo(gpo),
        .gpen(gpen), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        exp_q.push_back(exp);
        check(tag, obs);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, input logic [31:0] exp,
                            input logic exp_err, input string tag);
        exp_q.push_back(exp);
        exp_q.push_back({31'd0, exp_err});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check(tag, prdata);
        check({tag, "_err"}, {31'd0, pslverr});
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Setup-phase-only read: prdata is combinational while psel is high.
    task automatic peek(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        #1;
        check(tag, prdata);
        psel = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 12'h000; pwdata = 32'h0; gpi = 8'h00;
        repeat (3) tick();
        expect_now("rst_core_resetn", {28'd0, core_resetn}, 32'h0);
        expect_now("rst_gpo", {24'd0, gpo}, 32'h0);
        expect_now("rst_gpen", {24'd0, gpen}, 32'h0);
        expect_now("rst_irq", {31'd0, irq}, 32'h0);
        expect_now("pready", {31'd0, pready}, 32'h1);
        reset = 1'b0;

        apb_read(12'h004, 32'h0000_0000, 1'b0, "rst_core_stat");
        apb_read(12'h000, 32'h0000_0000, 1'b0, "rst_core_run");
        apb_read(12'h008, 32'h0000_0000, 1'b0, "rst_gpio_out");
        apb_read(12'h00C, 32'h0000_0000, 1'b0, "rst_gpio_oe");
        apb_read(12'h010, 32'h0000_0000, 1'b0, "rst_gpio_in");
        apb_read(12'h014, 32'h0000_0000, 1'b0, "rst_gpio_edge");
        apb_read(12'h018, 32'h0000_0000, 1'b0, "rst_gpio_ie");
        apb_read(12'h01C, 32'hF504_0802, 1'b0, "id");
        apb_read(12'h020, 32'h0000_0000, 1'b1, "unmapped");

        // Hold completes; release cores 0 and 2.
        repeat (20) tick();
        peek(12'h004, 32'h000F_0000, "stat_hold_done");
        apb_write(12'h000, 32'h0000_0005);
        expect_now("run_write_edge", {28'd0, core_resetn}, 32'h0);
        tick();
        expect_now("run_release", {28'd0, core_resetn}, 32'h5);
        peek(12'h004, 32'h000F_0005, "stat_running");
        peek(12'h000, 32'h0000_0005, "core_run_rb");

        // Drop core 0, re-request immediately, measure the low time.
        apb_write(12'h000, 32'h0000_0004);
        expect_now("drop_write_edge", {28'd0, core_resetn}, 32'h5);
        apb_write(12'h000, 32'h0000_0005);
        expect_now("drop_low", {28'd0, core_resetn}, 32'h4);
        n = 1;
        while (core_resetn[0] === 1'b0 && n < 100) begin
            tick();
            n++;
        end
        expect_now("hold_low_cycles", n, 32'd17);
        expect_now("rerelease", {28'd0, core_resetn}, 32'h5);

        // GPIO outputs.
        apb_write(12'h00C, 32'h0000_00F0);
        expect_now("gpen", {24'd0, gpen}, 32'hF0);
        apb_write(12'h008, 32'h0000_00A5);
        expect_now("gpo", {24'd0, gpo}, 32'hA5);
        peek(12'h00C, 32'h0000_00F0, "gpio_oe_rb");
        peek(12'h008, 32'h0000_00A5, "gpio_out_rb");

        // Rising edge on gpi[0] with its interrupt enabled.
        apb_write(12'h018, 32'h0000_0001);
        gpi = 8'h01;
        tick();
        peek(12'h010, 32'h0000_0000, "gpi_k");
        tick();
        peek(12'h010, 32'h0000_0001, "gpi_k1");
        peek(12'h014, 32'h0000_0000, "edge_k1");
        expect_now("irq_k1", {31'd0, irq}, 32'h0);
        tick();
        peek(12'h014, 32'h0000_0001, "edge_k2");
        expect_now("irq_k2", {31'd0, irq}, 32'h1);
        apb_write(12'h014, 32'h0000_0001);
        peek(12'h014, 32'h0000_0000, "edge_w1c");
        expect_now("irq_w1c", {31'd0, irq}, 32'h0);
        gpi = 8'h00;
        repeat (4) tick();
        peek(12'h014, 32'h0000_0000, "edge_fall");
        peek(12'h010, 32'h0000_0000, "gpi_fall");

        // Rise on gpi[2] coinciding with a W1C of bit 2.
        gpi = 8'h04;
        repeat (3) tick();
        peek(12'h014, 32'h0000_0004, "edge2_set");
        expect_now("irq_masked", {31'd0, irq}, 32'h0);
        gpi = 8'h00;
        repeat (3) tick();
        gpi = 8'h04;
        tick();
        apb_write(12'h014, 32'h0000_0004);
        peek(12'h014, 32'h0000_0004, "edge2_set_wins");
        apb_write(12'h014, 32'h0000_0004);
        peek(12'h014, 32'h0000_0000, "edge2_cleared");

        // Writes to read-only and unmapped offsets.
        apb_write(12'h01C, 32'h1234_5678);
        apb_write(12'h024, 32'hFFFF_FFFF);
        apb_read(12'h01C, 32'hF504_0802, 1'b0, "id_after_write");
        apb_read(12'h008, 32'h0000_00A5, 1'b0, "gpio_out_unchanged");

        // Reset mid-run forces every core low and clears the registers.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_now("midrun_resetn", {28'd0, core_resetn}, 32'h0);
        expect_now("midrun_gpo", {24'd0, gpo}, 32'h0);
        expect_now("midrun_gpen", {24'd0, gpen}, 32'h0);
        peek(12'h004, 32'h0000_0000, "midrun_stat");
        peek(12'h000, 32'h0000_0000, "midrun_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
